cpu_step_ctrl: RTL and testbench

//  Turns the divided slow clock and a push-button into a one-cycle CPU clock-enable.

---
 rtl/cpu_step_ctrl_pkg.sv | 18 +
 rtl/cpu_step_ctrl_if.sv | 11 +
 rtl/cpu_step_ctrl_btn_debounce.sv | 44 ++++
 rtl/cpu_step_ctrl.sv | 114 +++++++++++
 tb/tb_cpu_step_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared encodings for the CPU step controller: run-state values and reset polarity.
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_STEP = 2'b01,
    ST_SLOW = 2'b10,
    ST_FAST = 2'b11
  } run_state_e;

  localparam logic RST_ENABLE = 1'b0;

  // Only the tick-driven modes may hold a single deferred request.
  function automatic logic can_queue(input run_state_e s);
    return (s == ST_STEP) || (s == ST_SLOW);
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// CPU-facing handshake: clock-enable out, stall back, issued-step count for the display.
interface cpu_step_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             cpu_ce;
  logic             cpu_stall;
  logic [CNT_W-1:0] step_cnt;

  modport master (output cpu_ce, output step_cnt, input cpu_stall);
  modport slave  (input cpu_ce, input step_cnt, output cpu_stall);
endinterface

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Push-button debouncer: the settled level follows raw only after a full run of agreeing samples.
module btn_debounce
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          r_rise;

  // A sample matching the settled level restarts the run of differing samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (raw == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt    <= '0;
        r_stable <= raw;
        r_rise   <= raw;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;
  assign rise   = r_rise;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns the divided slow clock or a debounced push-button into a one-cycle CPU clock-enable,
// selected by the run-mode switches; counts issued steps and flags ticks lost to stalls.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  slow_clk,
  input  logic [1:0]            mode,
  input  logic                  step_btn,
  cpu_step_ctrl_if.master       cpu,
  output logic [1:0]            state,
  output logic                  overrun
);

  logic [1:0]       r_mode_s1, r_mode_s2;
  logic             r_btn_s1, r_btn_s2;
  logic             r_slow_q1, r_slow_q2;
  run_state_e       r_state;
  logic             r_pending;
  logic             r_overrun;
  logic             r_cpu_ce;
  logic [CNT_W-1:0] r_step_cnt;

  logic       w_btn_stable, w_btn_rise;
  logic       w_slow_tick, w_step_tick;
  run_state_e w_mode_sync;
  logic       w_chg, w_req, w_issue;

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      r_mode_s1 <= 2'b00;
      r_mode_s2 <= 2'b00;
      r_btn_s1  <= 1'b0;
      r_btn_s2  <= 1'b0;
      r_slow_q1 <= 1'b0;
      r_slow_q2 <= 1'b0;
    end else begin
      r_mode_s1 <= mode;
      r_mode_s2 <= r_mode_s1;
      r_btn_s1  <= step_btn;
      r_btn_s2  <= r_btn_s1;
      r_slow_q1 <= slow_clk;
      r_slow_q2 <= r_slow_q1;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .resetn (resetn),
    .raw    (r_btn_s2),
    .stable (w_btn_stable),
    .rise   (w_btn_rise)
  );

  assign w_slow_tick = r_slow_q1 & ~r_slow_q2;
  assign w_step_tick = w_btn_rise & w_btn_stable;
  assign w_mode_sync = run_state_e'(r_mode_s2);
  assign w_chg       = (w_mode_sync != r_state);

  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      ST_HALT: w_req = 1'b0;
      ST_STEP: w_req = w_step_tick;
      ST_SLOW: w_req = w_slow_tick;
      ST_FAST: w_req = 1'b1;
    endcase
  end

  // A state change swallows whatever request lands on the same cycle.
  assign w_issue = ~w_chg & (w_req | r_pending) & ~cpu.cpu_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      r_state   <= ST_HALT;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_cpu_ce  <= 1'b0;
    end else begin
      r_cpu_ce <= w_issue;
      if (w_chg) begin
        r_state   <= w_mode_sync;
        r_pending <= 1'b0;
        if (w_mode_sync == ST_HALT) r_overrun <= 1'b0;
      end else if (w_issue) begin
        r_pending <= 1'b0;
      end else if (w_req && cpu.cpu_stall && can_queue(r_state)) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end
    end
  end

  // Free-running count of issued enables; wraps silently.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RST_ENABLE) begin
      r_step_cnt <= '0;
    end else if (r_cpu_ce) begin
      r_step_cnt <= r_step_cnt + CNT_W'(1);
    end
  end

  assign cpu.cpu_ce   = r_cpu_ce;
  assign cpu.step_cnt = r_step_cnt;
  assign state        = r_state;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: expected enable cycles are queued as stimulus is driven
// and retired by a negedge monitor whenever cpu_ce is seen high.
module tb_cpu_step_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       slow_clk = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       step_btn = 1'b0;
  logic [1:0] state;
  logic       overrun;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  int exp_q[$];

  cpu_step_ctrl_if #(.CNT_W(32)) bus ();

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(32)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .slow_clk (slow_clk),
    .mode     (mode),
    .step_btn (step_btn),
    .cpu      (bus),
    .state    (state),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    tick(3);
    chk("state_after_mode", {62'd0, state}, {62'd0, m});
  endtask

  // One slow_clk period; the enable is expected two edges after the level is driven.
  task automatic slow_period(input bit expect_ce);
    slow_clk = 1'b1;
    if (expect_ce) exp_q.push_back(cyc + 2);
    tick(4);
    slow_clk = 1'b0;
    tick(4);
  endtask

  always @(negedge clk) begin
    if (mon_en && resetn && bus.cpu_ce === 1'b1) begin
      if (exp_q.size() == 0) chk("ce_unexpected", {63'd0, bus.cpu_ce}, 64'd0);
      else                   chk("ce_cycle", cyc, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int b;
    bus.cpu_stall = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("rst_ce",      {63'd0, bus.cpu_ce}, 64'd0);
    chk("rst_cnt",     bus.step_cnt, 64'd0);
    chk("rst_state",   {62'd0, state}, 64'd0);
    chk("rst_overrun", {63'd0, overrun}, 64'd0);
    tick(2);
    resetn = 1'b1;
    tick(1);
    mon_en = 1'b1;

    // Slow run: one enable per slow_clk rise.
    set_mode(2'b10);
    repeat (3) slow_period(1'b1);
    chk("slow_cnt", bus.step_cnt, 64'd3);

    // Asynchronous reset while an enable is on the output.
    mon_en = 1'b0;
    slow_clk = 1'b1;
    tick(2);
    chk("pre_rst_ce",    {63'd0, bus.cpu_ce}, 64'd1);
    chk("pre_rst_state", {62'd0, state}, 64'd2);
    resetn = 1'b0;
    #1;
    chk("async_ce",      {63'd0, bus.cpu_ce}, 64'd0);
    chk("async_cnt",     bus.step_cnt, 64'd0);
    chk("async_state",   {62'd0, state}, 64'd0);
    chk("async_overrun", {63'd0, overrun}, 64'd0);
    slow_clk = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(4);
    chk("resume_state", {62'd0, state}, 64'd2);
    mon_en = 1'b1;

    // Single step with a bouncing press, then a clean release and re-press.
    set_mode(2'b01);
    b = cyc;
    step_btn = 1'b1; tick(1);
    step_btn = 1'b0; tick(1);
    step_btn = 1'b1;
    exp_q.push_back(b + 9);
    tick(20);
    chk("step_cnt_1", bus.step_cnt, 64'd1);
    step_btn = 1'b0;
    tick(10);
    chk("step_hold_cnt", bus.step_cnt, 64'd1);
    step_btn = 1'b1;
    exp_q.push_back(cyc + 7);
    tick(12);
    chk("step_cnt_2", bus.step_cnt, 64'd2);
    step_btn = 1'b0;
    tick(10);

    // Stalled slow ticks: one held, the second dropped and flagged.
    set_mode(2'b10);
    bus.cpu_stall = 1'b1;
    slow_period(1'b0);
    chk("ovr_after_one", {63'd0, overrun}, 64'd0);
    slow_period(1'b0);
    chk("ovr_set",       {63'd0, overrun}, 64'd1);
    chk("ovr_cnt_held",  bus.step_cnt, 64'd2);
    bus.cpu_stall = 1'b0;
    exp_q.push_back(cyc + 1);
    tick(3);
    chk("ovr_cnt_issue", bus.step_cnt, 64'd3);
    chk("ovr_sticky",    {63'd0, overrun}, 64'd1);
    set_mode(2'b00);
    chk("ovr_halt_clr",  {63'd0, overrun}, 64'd0);

    // Full speed: enable mirrors ~stall one cycle later.
    bus.cpu_stall = 1'b1;
    set_mode(2'b11);
    for (int i = 0; i < 16; i++) begin
      bus.cpu_stall = ((i % 4) == 3);
      if (!bus.cpu_stall) exp_q.push_back(cyc + 1);
      tick(1);
    end
    bus.cpu_stall = 1'b1;
    tick(2);
    chk("fast_cnt",     bus.step_cnt, 64'd15);
    chk("fast_overrun", {63'd0, overrun}, 64'd0);

    // Counter wrap from a preloaded value near all-ones.
    force dut.r_step_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_step_cnt;
    bus.cpu_stall = 1'b0;
    exp_q.push_back(cyc + 1); tick(1);
    exp_q.push_back(cyc + 1); tick(1);
    exp_q.push_back(cyc + 1); tick(1);
    bus.cpu_stall = 1'b1;
    chk("wrap_zero", bus.step_cnt, 64'd0);
    tick(1);
    chk("wrap_one",  bus.step_cnt, 64'd1);

    // Mode switch landing on the same cycle as a slow tick.
    set_mode(2'b10);
    bus.cpu_stall = 1'b0;
    mode = 2'b01;
    tick(1);
    slow_clk = 1'b1;
    tick(1);
    chk("chg_state_old", {62'd0, state}, 64'd2);
    tick(1);
    chk("chg_state_new", {62'd0, state}, 64'd1);
    tick(4);
    slow_clk = 1'b0;
    tick(2);
    chk("chg_cnt_kept", bus.step_cnt, 64'd1);

    chk("queue_drained", exp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
